// File: rtl/imp_rx.sv
// Pulse-line receiver: synchronizes imp, measures each high pulse in clk cycles, flags over-long pulses.
// Optional IMP_RX_CNT_EN adds a saturating ok_cnt output counting pulses that matched EXP_LEN.
module imp_rx #(
    parameter int EXP_LEN = 3,
    parameter int MAX_LEN = 15,
    parameter int CW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          imp,
    output logic          done,
    output logic [CW-1:0] len,
    output logic          ok,
    output logic          err_long
`ifdef IMP_RX_CNT_EN
    ,
    output logic [7:0]    ok_cnt
`endif
);

    localparam logic [CW-1:0] MAXC = CW'(MAX_LEN);
    localparam logic [CW-1:0] EXPC = CW'(EXP_LEN);

    typedef enum logic [1:0] {WAIT_LOW, IDLE, HIGH, OVF} state_t;

    state_t        state, state_n;
    logic          s1, imp_s;
    logic [CW-1:0] cnt, cnt_n, len_n;
    logic          done_n, ok_n, err_n;

    // Sync flops reset high so a line already asserted at reset is not a fresh pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= 1'b1;
            imp_s    <= 1'b1;
            state    <= WAIT_LOW;
            cnt      <= '0;
            done     <= 1'b0;
            len      <= '0;
            ok       <= 1'b0;
            err_long <= 1'b0;
        end else begin
            s1       <= imp;
            imp_s    <= s1;
            state    <= state_n;
            cnt      <= cnt_n;
            done     <= done_n;
            len      <= len_n;
            ok       <= ok_n;
            err_long <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        len_n   = len;
        done_n  = 1'b0;
        ok_n    = 1'b0;
        err_n   = 1'b0;
        case (state)
            WAIT_LOW: if (!imp_s) state_n = IDLE;
            IDLE: begin
                if (imp_s) begin
                    cnt_n   = CW'(1);
                    state_n = HIGH;
                end
            end
            HIGH: begin
                if (!imp_s) begin
                    done_n  = 1'b1;
                    len_n   = cnt;
                    ok_n    = (cnt == EXPC);
                    state_n = IDLE;
                end else if (cnt == MAXC) begin
                    // Counter stops at MAX_LEN; the extra cycle is the overflow.
                    err_n   = 1'b1;
                    state_n = OVF;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            OVF: if (!imp_s) state_n = IDLE;
            default: state_n = WAIT_LOW;
        endcase
    end

`ifdef IMP_RX_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            ok_cnt <= 8'd0;
        else if (done && ok && ok_cnt != 8'hFF)
            ok_cnt <= ok_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_imp_rx.sv
// Self-checking bench for imp_rx: vector table, hand-written corner sequences and random pulses
// checked every cycle against a run-length model of the delayed imp stream.
module tb_imp_rx;
    localparam int EXP_LEN = 3;
    localparam int MAX_LEN = 15;
    localparam int CW      = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          imp = 1'b0;
    logic          done, ok, err_long;
    logic [CW-1:0] len;
`ifdef IMP_RX_CNT_EN
    logic [7:0]    ok_cnt;
`endif

    imp_rx #(.EXP_LEN(EXP_LEN), .MAX_LEN(MAX_LEN), .CW(CW)) dut (
        .clk(clk), .rst(rst), .imp(imp), .done(done), .len(len), .ok(ok), .err_long(err_long)
`ifdef IMP_RX_CNT_EN
        , .ok_cnt(ok_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: imp as seen two edges late, reduced to run lengths of high samples.
    int  cyc = 0;
    bit  dl[2] = '{1'b1, 1'b1};
    bit  armed = 0;
    int  run = 0;
    bit  e_done = 0, e_ok = 0, e_err = 0;
    int  e_len = 0;
    int  e_okc = 0;
    bit  chk_en = 0;

    always @(posedge clk) begin
        bit v;
        cyc++;
        if (rst) begin
            dl = '{1'b1, 1'b1};
            armed = 0; run = 0;
            e_done = 0; e_ok = 0; e_err = 0; e_len = 0; e_okc = 0;
        end else begin
            if (e_done && e_ok && e_okc < 255) e_okc++;
            v = dl[1];
            dl[1] = dl[0];
            dl[0] = imp;
            e_done = 0; e_ok = 0; e_err = 0;
            if (!armed) begin
                if (!v) armed = 1;
            end else if (v) begin
                run++;
                if (run == MAX_LEN + 1) e_err = 1;
            end else begin
                if (run > 0 && run <= MAX_LEN) begin
                    e_done = 1;
                    e_len  = run;
                    e_ok   = (run == EXP_LEN);
                end
                run = 0;
            end
        end
    end

    // Strobe monitor plus per-cycle comparison against the model.
    int n_done = 0, n_err = 0, done_cyc = 0;
    int len_a = 0, len_b = 0;
    bit ok_a = 0, ok_b = 0;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
            len_a = len_b; ok_a = ok_b;
            len_b = int'(len); ok_b = ok;
        end
        if (err_long === 1'b1) n_err++;
        if (chk_en) begin
            chk("cyc_done", int'(done), int'(e_done));
            chk("cyc_len", int'(len), e_len);
            chk("cyc_ok", int'(ok), int'(e_ok));
            chk("cyc_err", int'(err_long), int'(e_err));
`ifdef IMP_RX_CNT_EN
            chk("cyc_okcnt", int'(ok_cnt), e_okc);
`endif
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int hi, input int lo);
        imp = 1'b1; tick(hi);
        imp = 1'b0; tick(lo);
    endtask

    typedef struct {
        int hi; int lo; int nd; int ln; bit okv; int ne;
    } vec_t;

    initial begin
        vec_t vt[8];
        int bd, be, fall;

        vt[0] = '{3,  4, 1, 3,  1'b1, 0};
        vt[1] = '{5,  4, 1, 5,  1'b0, 0};
        vt[2] = '{1,  4, 1, 1,  1'b0, 0};
        vt[3] = '{15, 4, 1, 15, 1'b0, 0};
        vt[4] = '{16, 4, 0, 0,  1'b0, 1};
        vt[5] = '{3,  4, 1, 3,  1'b1, 0};
        vt[6] = '{14, 4, 1, 14, 1'b0, 0};
        vt[7] = '{22, 4, 0, 0,  1'b0, 1};

        rst = 1'b1; imp = 1'b0;
        tick(1);
        chk_en = 1;
        tick(2);
        chk("rst_done", int'(done), 0);
        chk("rst_len", int'(len), 0);
        chk("rst_ok", int'(ok), 0);
        chk("rst_err", int'(err_long), 0);
        rst = 1'b0;
        tick(3);

        // First pulse and its output latency relative to the falling edge.
        bd = n_done;
        imp = 1'b1; tick(3);
        imp = 1'b0; fall = cyc; tick(5);
        chk("p3_ndone", n_done - bd, 1);
        chk("p3_len", len_b, 3);
        chk("p3_ok", int'(ok_b), 1);
        chk("p3_latency", done_cyc - fall, 3);

        // One-cycle gap between pulses must not lose the second pulse.
        bd = n_done;
        pulse(5, 1);
        pulse(3, 5);
        chk("gap_ndone", n_done - bd, 2);
        chk("gap_len1", len_a, 5);
        chk("gap_ok1", int'(ok_a), 0);
        chk("gap_len2", len_b, 3);
        chk("gap_ok2", int'(ok_b), 1);

        for (int i = 0; i < 8; i++) begin
            bd = n_done; be = n_err;
            pulse(vt[i].hi, vt[i].lo);
            chk($sformatf("vec%0d_ndone", i), n_done - bd, vt[i].nd);
            chk($sformatf("vec%0d_nerr", i), n_err - be, vt[i].ne);
            if (vt[i].nd > 0) begin
                chk($sformatf("vec%0d_len", i), len_b, vt[i].ln);
                chk($sformatf("vec%0d_ok", i), int'(ok_b), int'(vt[i].okv));
            end
        end

        // Line held high through reset is ignored until seen low.
        bd = n_done; be = n_err;
        imp = 1'b1; rst = 1'b1; tick(2);
        rst = 1'b0; tick(10);
        imp = 1'b0; tick(4);
        chk("hirst_ndone", n_done - bd, 0);
        chk("hirst_nerr", n_err - be, 0);
        pulse(3, 5);
        chk("hirst_next_ndone", n_done - bd, 1);
        chk("hirst_next_len", len_b, 3);

        // Reset on the 2nd high cycle of a 6-cycle pulse drops that pulse.
        bd = n_done; be = n_err;
        imp = 1'b1; tick(1);
        rst = 1'b1; tick(1);
        rst = 1'b0;
        chk("midrst_done", int'(done), 0);
        chk("midrst_len", int'(len), 0);
        chk("midrst_ok", int'(ok), 0);
        tick(4);
        imp = 1'b0; tick(4);
        chk("midrst_ndone", n_done - bd, 0);
        chk("midrst_nerr", n_err - be, 0);
        pulse(3, 5);
        chk("midrst_next_len", len_b, 3);
        chk("midrst_next_ok", int'(ok_b), 1);

        // Random pulse trains; the per-cycle model comparison does the checking.
        for (int i = 0; i < 200; i++)
            pulse($urandom_range(1, 18), $urandom_range(1, 4));
        tick(5);

`ifdef IMP_RX_CNT_EN
        for (int i = 0; i < 300; i++) pulse(3, 2);
        tick(5);
        chk("okcnt_sat", int'(ok_cnt), 255);
        pulse(4, 5);
        chk("okcnt_hold", int'(ok_cnt), 255);
`endif

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
